operand_fetch_stage: RTL and testbench
======================================

OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

Interface
REQ-001 SHALL have ports: clk in 1, pipeline clock; reset in 1, asynchronous active-high reset.
REQ-002 SHALL accept from thread_select_stage: ts_instruction_valid in 1; ts_instruction in decoded_instruction_t; ts_thread_idx in local_thread_idx_t; ts_subcycle in subcycle_t.
REQ-003 SHALL accept from writeback_stage: wb_rollback_en in 1; wb_rollback_thread_idx in local_thread_idx_t.
REQ-004 SHALL accept register writes: wb_writeback_en in 1; wb_writeback_thread_idx in local_thread_idx_t; wb_writeback_vector in 1; wb_writeback_value in vector_t; wb_writeback_mask in vector_mask_t; wb_writeback_reg in register_idx_t.
REQ-005 SHALL drive to execute stages: of_instruction_valid out 1; of_instruction out decoded_instruction_t; of_thread_idx out local_thread_idx_t; of_subcycle out subcycle_t; of_operand1, of_operand2, of_store_value out vector_t; of_mask_value out vector_mask_t.

Function
REQ-006 SHALL hold one scalar file (THREADS_PER_CORE x NUM_REGISTERS x 32b) and one vector file per lane (same depth), each with two read ports and one write port, addressed {thread_idx, reg}.
REQ-007 SHALL issue reads in the ts_ cycle from scalar_sel1/scalar_sel2/vector_sel1/vector_sel2; of_* outputs valid exactly one cycle later (latency 1, no stall, one instruction per cycle).
REQ-008 SHALL register of_instruction, of_thread_idx, of_subcycle unconditionally each cycle.
REQ-009 SHALL set of_instruction_valid next cycle to ts_instruction_valid && !(wb_rollback_en && wb_rollback_thread_idx == ts_thread_idx); rollback of other threads does not squash.
REQ-010 of_operand1: vector1 read if op1_is_vector, else scalar1 replicated to all lanes.
REQ-011 of_operand2: per op2_src -- OP2_SRC_SCALAR2 replicated scalar2; OP2_SRC_VECTOR2 vector2 read; OP2_SRC_IMMEDIATE immediate_value replicated.
REQ-012 of_mask_value: per mask_src -- MASK_SRC_SCALAR1 scalar1[15:0]; MASK_SRC_SCALAR2 scalar2[15:0]; MASK_SRC_ALL_ONES 16'hffff.
REQ-013 of_store_value: vector2 read if store_value_is_vector, else {lanes 1..15 = 0, lane 0 = scalar2}.
REQ-014 Write when wb_writeback_en: if wb_writeback_vector, lane i written with wb_writeback_value[i] only where wb_writeback_mask[i]; else scalar file written with lane 0 value, mask ignored.
REQ-015 Writes SHALL occur regardless of rollback or read activity; write and read in the same cycle to different addresses SHALL both complete.
REQ-016 Reads of invalid instructions SHALL not be suppressed; operand outputs for invalid slots are don't-care.

Reset
REQ-017 During reset of_instruction_valid SHALL be 0 immediately (asynchronous); all other outputs and register file contents are not reset and are undefined until written.
REQ-018 Reset asserted mid-stream SHALL drop the in-flight instruction; first valid output appears one cycle after the first valid ts_ input following deassertion.

Configuration
REQ-019 Macro REGFILE_WRITE_BYPASS_EN: when defined, a read to the address written in the same cycle SHALL return the new data (vector: per lane, only masked lanes bypassed); when undefined SHALL return the old data, thread_select scoreboard guaranteeing no such hazard.

Structure
REQ-020 defines package SHALL hold NUM_REGISTERS (32), register_idx_t, op2_src_t, mask_src_t, and the decoded_instruction_t fields used above.
REQ-021 Storage SHALL use one sub-module sram_2r1w (parameters DATA_WIDTH, SIZE, READ_DURING_WRITE), instantiated once for scalars and once per vector lane.

Verification
REQ-022 Write s3 = 0x12345678 thread 1, then read op1 scalar s3 thread 1 -> of_operand1 all 16 lanes 0x12345678 one cycle later.
REQ-023 Write v5 thread 0 lanes i=0x100+i, mask 0x00ff, prior v5 = 0 -> read v5 gives lanes 0-7 = 0x100..0x107, lanes 8-15 = 0.
REQ-024 ts_instruction_valid=1 thread 2 with wb_rollback_en=1 thread 2 -> of_instruction_valid=0; same with rollback thread 3 -> 1.
REQ-025 Same-cycle write s7=0xAA and read s7 (old 0x55) -> 0xAA with REGFILE_WRITE_BYPASS_EN, 0x55 without.
REQ-026 op2_src IMMEDIATE, immediate 0xFFFFFFF0, mask_src ALL_ONES -> of_operand2 all lanes 0xFFFFFFF0, of_mask_value 0xffff.
REQ-027 Assert reset while valid=1 in flight -> of_instruction_valid 0 same cycle, remains 0 until one cycle after next valid input.

Source files
------------

// File: rtl/operand_fetch_stage_pkg.sv
// Shared types for the operand fetch stage: register indices, vector types and the
// decoded instruction fields consumed when selecting operands.
package operand_fetch_stage_pkg;

  localparam int unsigned NUM_REGISTERS    = 32;
  localparam int unsigned THREADS_PER_CORE = 4;
  localparam int unsigned NUM_VECTOR_LANES = 16;

  typedef logic [$clog2(NUM_REGISTERS)-1:0]    register_idx_t;
  typedef logic [$clog2(THREADS_PER_CORE)-1:0] local_thread_idx_t;
  typedef logic [3:0]                          subcycle_t;
  typedef logic [31:0]                         scalar_t;
  typedef scalar_t [NUM_VECTOR_LANES-1:0]      vector_t;
  typedef logic [NUM_VECTOR_LANES-1:0]         vector_mask_t;

  typedef enum logic [1:0] {
    OP2_SRC_SCALAR2   = 2'd0,
    OP2_SRC_VECTOR2   = 2'd1,
    OP2_SRC_IMMEDIATE = 2'd2
  } op2_src_t;

  typedef enum logic [1:0] {
    MASK_SRC_SCALAR1  = 2'd0,
    MASK_SRC_SCALAR2  = 2'd1,
    MASK_SRC_ALL_ONES = 2'd2
  } mask_src_t;

  typedef struct packed {
    register_idx_t scalar_sel1;
    register_idx_t scalar_sel2;
    register_idx_t vector_sel1;
    register_idx_t vector_sel2;
    logic          op1_is_vector;
    op2_src_t      op2_src;
    mask_src_t     mask_src;
    logic          store_value_is_vector;
    scalar_t       immediate_value;
  } decoded_instruction_t;

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Bundles the thread-select, writeback and execute-side signals of the operand fetch stage.
// The stage itself connects through the slave modport.
interface operand_fetch_stage_if;
  import operand_fetch_stage_pkg::*;

  logic                 ts_instruction_valid;
  decoded_instruction_t ts_instruction;
  local_thread_idx_t    ts_thread_idx;
  subcycle_t            ts_subcycle;

  logic                 wb_rollback_en;
  local_thread_idx_t    wb_rollback_thread_idx;

  logic                 wb_writeback_en;
  local_thread_idx_t    wb_writeback_thread_idx;
  logic                 wb_writeback_vector;
  vector_t              wb_writeback_value;
  vector_mask_t         wb_writeback_mask;
  register_idx_t        wb_writeback_reg;

  logic                 of_instruction_valid;
  decoded_instruction_t of_instruction;
  local_thread_idx_t    of_thread_idx;
  subcycle_t            of_subcycle;
  vector_t              of_operand1;
  vector_t              of_operand2;
  vector_t              of_store_value;
  vector_mask_t         of_mask_value;

  modport master (
    output ts_instruction_valid, ts_instruction, ts_thread_idx, ts_subcycle,
    output wb_rollback_en, wb_rollback_thread_idx,
    output wb_writeback_en, wb_writeback_thread_idx, wb_writeback_vector,
    output wb_writeback_value, wb_writeback_mask, wb_writeback_reg,
    input  of_instruction_valid, of_instruction, of_thread_idx, of_subcycle,
    input  of_operand1, of_operand2, of_store_value, of_mask_value
  );

  modport slave (
    input  ts_instruction_valid, ts_instruction, ts_thread_idx, ts_subcycle,
    input  wb_rollback_en, wb_rollback_thread_idx,
    input  wb_writeback_en, wb_writeback_thread_idx, wb_writeback_vector,
    input  wb_writeback_value, wb_writeback_mask, wb_writeback_reg,
    output of_instruction_valid, of_instruction, of_thread_idx, of_subcycle,
    output of_operand1, of_operand2, of_store_value, of_mask_value
  );
endinterface

// File: rtl/sram_2r1w.sv
// Two-read one-write memory with registered read data (latency 1), no reset on contents.
// READ_DURING_WRITE selects whether a same-address read returns the data being written.
module sram_2r1w #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned SIZE              = 128,
  parameter bit          READ_DURING_WRITE = 1'b0,
  localparam int unsigned AddrWidth        = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic [AddrWidth-1:0]  read1_addr,
  output logic [DATA_WIDTH-1:0] read1_data,
  input  logic [AddrWidth-1:0]  read2_addr,
  output logic [DATA_WIDTH-1:0] read2_data,
  input  logic                  write_en,
  input  logic [AddrWidth-1:0]  write_addr,
  input  logic [DATA_WIDTH-1:0] write_data
);

  logic [DATA_WIDTH-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
    if (READ_DURING_WRITE && write_en && (write_addr == read1_addr)) begin
      read1_data <= write_data;
    end else begin
      read1_data <= mem[read1_addr];
    end
    if (READ_DURING_WRITE && write_en && (write_addr == read2_addr)) begin
      read2_data <= write_data;
    end else begin
      read2_data <= mem[read2_addr];
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: reads scalar/vector register files one cycle ahead and selects operands.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle writes to reads of the same address.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  operand_fetch_stage_if.slave bus
);

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  localparam int unsigned RfSize  = THREADS_PER_CORE * NUM_REGISTERS;
  localparam int unsigned RfAddrW = $clog2(RfSize);

  logic [RfAddrW-1:0] s1_addr, s2_addr, v1_addr, v2_addr, wb_addr;
  scalar_t            scalar1, scalar2;
  vector_t            vector1, vector2;

  logic                 valid_q;
  decoded_instruction_t instr_q;
  local_thread_idx_t    thread_q;
  subcycle_t            subcycle_q;

  assign s1_addr = {bus.ts_thread_idx, bus.ts_instruction.scalar_sel1};
  assign s2_addr = {bus.ts_thread_idx, bus.ts_instruction.scalar_sel2};
  assign v1_addr = {bus.ts_thread_idx, bus.ts_instruction.vector_sel1};
  assign v2_addr = {bus.ts_thread_idx, bus.ts_instruction.vector_sel2};
  assign wb_addr = {bus.wb_writeback_thread_idx, bus.wb_writeback_reg};

  sram_2r1w #(
    .DATA_WIDTH        (32),
    .SIZE              (RfSize),
    .READ_DURING_WRITE (Bypass)
  ) scalar_rf (
    .clk        (clk),
    .read1_addr (s1_addr),
    .read1_data (scalar1),
    .read2_addr (s2_addr),
    .read2_data (scalar2),
    .write_en   (bus.wb_writeback_en && !bus.wb_writeback_vector),
    .write_addr (wb_addr),
    .write_data (bus.wb_writeback_value[0])
  );

  // Per-lane write enables give masked writes and per-lane bypass for free.
  for (genvar lane = 0; lane < NUM_VECTOR_LANES; lane++) begin : g_vector_rf
    sram_2r1w #(
      .DATA_WIDTH        (32),
      .SIZE              (RfSize),
      .READ_DURING_WRITE (Bypass)
    ) vector_rf (
      .clk        (clk),
      .read1_addr (v1_addr),
      .read1_data (vector1[lane]),
      .read2_addr (v2_addr),
      .read2_data (vector2[lane]),
      .write_en   (bus.wb_writeback_en && bus.wb_writeback_vector &&
                   bus.wb_writeback_mask[lane]),
      .write_addr (wb_addr),
      .write_data (bus.wb_writeback_value[lane])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.ts_instruction_valid &&
                 !(bus.wb_rollback_en && (bus.wb_rollback_thread_idx == bus.ts_thread_idx));
    end
  end

  always_ff @(posedge clk) begin
    instr_q    <= bus.ts_instruction;
    thread_q   <= bus.ts_thread_idx;
    subcycle_q <= bus.ts_subcycle;
  end

  assign bus.of_instruction_valid = valid_q;
  assign bus.of_instruction       = instr_q;
  assign bus.of_thread_idx        = thread_q;
  assign bus.of_subcycle          = subcycle_q;

  always_comb begin
    bus.of_operand1    = instr_q.op1_is_vector ? vector1 : {NUM_VECTOR_LANES{scalar1}};
    bus.of_operand2    = {NUM_VECTOR_LANES{scalar2}};
    bus.of_mask_value  = {NUM_VECTOR_LANES{1'b1}};
    bus.of_store_value = '0;

    case (instr_q.op2_src)
      OP2_SRC_VECTOR2:   bus.of_operand2 = vector2;
      OP2_SRC_IMMEDIATE: bus.of_operand2 = {NUM_VECTOR_LANES{instr_q.immediate_value}};
      default:           bus.of_operand2 = {NUM_VECTOR_LANES{scalar2}};
    endcase

    case (instr_q.mask_src)
      MASK_SRC_SCALAR1: bus.of_mask_value = scalar1[NUM_VECTOR_LANES-1:0];
      MASK_SRC_SCALAR2: bus.of_mask_value = scalar2[NUM_VECTOR_LANES-1:0];
      default:          bus.of_mask_value = {NUM_VECTOR_LANES{1'b1}};
    endcase

    if (instr_q.store_value_is_vector) begin
      bus.of_store_value = vector2;
    end else begin
      bus.of_store_value[0] = scalar2;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: register preload, table of operand reads,
// plus reset, rollback and same-cycle write/read sequences.
module tb_operand_fetch_stage;
  import operand_fetch_stage_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  operand_fetch_stage_if bus ();

  operand_fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    local_thread_idx_t    thread;
    subcycle_t            sub;
    decoded_instruction_t instr;
    vector_t              exp_op1;
    vector_t              exp_op2;
    vector_mask_t         exp_mask;
    vector_t              exp_store;
  } rec_t;

  rec_t recs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vector_t rep(input scalar_t x);
    return {NUM_VECTOR_LANES{x}};
  endfunction

  function automatic vector_t lane0(input scalar_t x);
    vector_t v = '0;
    v[0] = x;
    return v;
  endfunction

  function automatic vector_t ramp(input scalar_t base, input vector_mask_t m);
    vector_t v = '0;
    for (int i = 0; i < NUM_VECTOR_LANES; i++) v[i] = m[i] ? base + scalar_t'(i) : '0;
    return v;
  endfunction

  function automatic decoded_instruction_t mk(
      input register_idx_t s1, input register_idx_t s2, input register_idx_t v1,
      input register_idx_t v2, input logic op1v, input op2_src_t o2, input mask_src_t ms,
      input logic stv, input scalar_t imm);
    decoded_instruction_t d;
    d.scalar_sel1 = s1;  d.scalar_sel2 = s2;  d.vector_sel1 = v1;  d.vector_sel2 = v2;
    d.op1_is_vector = op1v;  d.op2_src = o2;  d.mask_src = ms;
    d.store_value_is_vector = stv;  d.immediate_value = imm;
    return d;
  endfunction

  // Scalar writes put junk in the other lanes and a zero mask: neither may matter.
  task automatic wr_scalar(input local_thread_idx_t t, input register_idx_t r, input scalar_t v);
    bus.wb_writeback_en = 1'b1;  bus.wb_writeback_vector = 1'b0;
    bus.wb_writeback_thread_idx = t;  bus.wb_writeback_reg = r;
    bus.wb_writeback_value = rep(~v);  bus.wb_writeback_value[0] = v;
    bus.wb_writeback_mask = '0;
    tick();
    bus.wb_writeback_en = 1'b0;
  endtask

  task automatic wr_vector(input local_thread_idx_t t, input register_idx_t r, input vector_t v,
                           input vector_mask_t m);
    bus.wb_writeback_en = 1'b1;  bus.wb_writeback_vector = 1'b1;
    bus.wb_writeback_thread_idx = t;  bus.wb_writeback_reg = r;
    bus.wb_writeback_value = v;  bus.wb_writeback_mask = m;
    tick();
    bus.wb_writeback_en = 1'b0;
  endtask

  task automatic issue(input local_thread_idx_t t, input subcycle_t s,
                       input decoded_instruction_t d);
    bus.ts_instruction_valid = 1'b1;
    bus.ts_thread_idx = t;  bus.ts_subcycle = s;  bus.ts_instruction = d;
  endtask

  initial begin
    bus.ts_instruction_valid = 1'b0;  bus.ts_instruction = '0;
    bus.ts_thread_idx = '0;  bus.ts_subcycle = '0;
    bus.wb_rollback_en = 1'b0;  bus.wb_rollback_thread_idx = '0;
    bus.wb_writeback_en = 1'b0;  bus.wb_writeback_thread_idx = '0;
    bus.wb_writeback_vector = 1'b0;  bus.wb_writeback_value = '0;
    bus.wb_writeback_mask = '0;  bus.wb_writeback_reg = '0;

    #12;
    chk("reset_valid", bus.of_instruction_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Preload register files
    wr_vector(2'd0, 5'd5, '0, 16'hffff);
    wr_vector(2'd0, 5'd5, ramp(32'h100, 16'hffff), 16'h00ff);
    wr_vector(2'd0, 5'd6, ramp(32'h200, 16'hffff), 16'hffff);
    wr_scalar(2'd1, 5'd3, 32'h1234_5678);
    wr_scalar(2'd1, 5'd4, 32'h0000_a5c3);
    wr_scalar(2'd2, 5'd1, 32'hdead_beef);
    wr_scalar(2'd0, 5'd3, 32'h0000_0033);

    recs[0] = '{thread: 2'd1, sub: 4'd0,
                instr: mk(5'd3, 5'd4, 5'd0, 5'd0, 1'b0, OP2_SRC_SCALAR2, MASK_SRC_SCALAR1, 1'b0, '0),
                exp_op1: rep(32'h1234_5678), exp_op2: rep(32'h0000_a5c3),
                exp_mask: 16'h5678, exp_store: lane0(32'h0000_a5c3)};
    recs[1] = '{thread: 2'd0, sub: 4'd1,
                instr: mk(5'd0, 5'd0, 5'd5, 5'd6, 1'b1, OP2_SRC_VECTOR2, MASK_SRC_ALL_ONES, 1'b1,
                          '0),
                exp_op1: ramp(32'h100, 16'h00ff), exp_op2: ramp(32'h200, 16'hffff),
                exp_mask: 16'hffff, exp_store: ramp(32'h200, 16'hffff)};
    recs[2] = '{thread: 2'd2, sub: 4'd2,
                instr: mk(5'd1, 5'd1, 5'd0, 5'd0, 1'b0, OP2_SRC_IMMEDIATE, MASK_SRC_ALL_ONES, 1'b0,
                          32'hffff_fff0),
                exp_op1: rep(32'hdead_beef), exp_op2: rep(32'hffff_fff0),
                exp_mask: 16'hffff, exp_store: lane0(32'hdead_beef)};
    recs[3] = '{thread: 2'd1, sub: 4'd3,
                instr: mk(5'd4, 5'd3, 5'd0, 5'd0, 1'b0, OP2_SRC_SCALAR2, MASK_SRC_SCALAR2, 1'b0, '0),
                exp_op1: rep(32'h0000_a5c3), exp_op2: rep(32'h1234_5678),
                exp_mask: 16'h5678, exp_store: lane0(32'h1234_5678)};
    recs[4] = '{thread: 2'd0, sub: 4'd15,
                instr: mk(5'd3, 5'd3, 5'd0, 5'd0, 1'b0, OP2_SRC_SCALAR2, MASK_SRC_SCALAR1, 1'b0, '0),
                exp_op1: rep(32'h33), exp_op2: rep(32'h33),
                exp_mask: 16'h0033, exp_store: lane0(32'h33)};

    foreach (recs[i]) begin
      issue(recs[i].thread, recs[i].sub, recs[i].instr);
      tick();
      chk($sformatf("rec%0d_valid", i), bus.of_instruction_valid, 1'b1);
      chk($sformatf("rec%0d_instr", i), bus.of_instruction, recs[i].instr);
      chk($sformatf("rec%0d_thread", i), bus.of_thread_idx, recs[i].thread);
      chk($sformatf("rec%0d_subcycle", i), bus.of_subcycle, recs[i].sub);
      chk($sformatf("rec%0d_op1", i), bus.of_operand1, recs[i].exp_op1);
      chk($sformatf("rec%0d_op2", i), bus.of_operand2, recs[i].exp_op2);
      chk($sformatf("rec%0d_mask", i), bus.of_mask_value, recs[i].exp_mask);
      chk($sformatf("rec%0d_store", i), bus.of_store_value, recs[i].exp_store);
    end

    // Rollback squashes only the matching thread
    issue(2'd2, 4'd0, recs[2].instr);
    bus.wb_rollback_en = 1'b1;  bus.wb_rollback_thread_idx = 2'd2;
    tick();
    chk("rollback_same_thread", bus.of_instruction_valid, 1'b0);
    bus.wb_rollback_thread_idx = 2'd3;
    tick();
    chk("rollback_other_thread", bus.of_instruction_valid, 1'b1);
    bus.wb_rollback_en = 1'b0;
    bus.ts_instruction_valid = 1'b0;
    tick();
    chk("idle_valid", bus.of_instruction_valid, 1'b0);

    // Same-cycle write and read of s7, with a concurrent read of another register
    wr_scalar(2'd0, 5'd7, 32'h55);
    issue(2'd0, 4'd0, mk(5'd7, 5'd3, 5'd0, 5'd0, 1'b0, OP2_SRC_SCALAR2, MASK_SRC_ALL_ONES, 1'b0,
                         '0));
    bus.wb_writeback_en = 1'b1;  bus.wb_writeback_vector = 1'b0;
    bus.wb_writeback_thread_idx = 2'd0;  bus.wb_writeback_reg = 5'd7;
    bus.wb_writeback_value = lane0(32'haa);
    tick();
    bus.wb_writeback_en = 1'b0;
`ifdef REGFILE_WRITE_BYPASS_EN
    chk("rdw_same_addr", bus.of_operand1, rep(32'haa));
`else
    chk("rdw_same_addr", bus.of_operand1, rep(32'h55));
`endif
    chk("rdw_other_addr", bus.of_operand2, rep(32'h33));
    tick();
    chk("rdw_write_landed", bus.of_operand1, rep(32'haa));

    // Reset with a valid instruction in flight
    issue(2'd1, 4'd0, recs[0].instr);
    tick();
    chk("inflight_valid", bus.of_instruction_valid, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_drop", bus.of_instruction_valid, 1'b0);
    bus.ts_instruction_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("post_reset_idle1", bus.of_instruction_valid, 1'b0);
    tick();
    chk("post_reset_idle2", bus.of_instruction_valid, 1'b0);
    issue(2'd1, 4'd0, recs[0].instr);
    #2;
    chk("pre_edge_still_0", bus.of_instruction_valid, 1'b0);
    tick();
    chk("first_valid_after_reset", bus.of_instruction_valid, 1'b1);
    chk("after_reset_op1", bus.of_operand1, rep(32'h1234_5678));
    bus.ts_instruction_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
